// File: rtl/approx_mac_pkg.sv
// rtl/approx_mac_pkg.sv - shared types and saturation helper for the approximate MAC pipeline
package approx_mac_pkg;

  typedef enum logic {MODE_EXACT, MODE_APPROX} mac_mode_e;

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

  // Widest accumulator sum the overflow helper accepts (ACC_W up to 64, plus carry).
  localparam int SAT_SUM_W = 65;

  // True when the sum does not fit in acc_w bits, i.e. the result must be clamped.
  function automatic logic sat_overflow(input logic [SAT_SUM_W-1:0] sum, input int acc_w);
    return |(sum >> acc_w);
  endfunction

endpackage

// File: rtl/approx_mult.sv
// rtl/approx_mult.sv - combinational exact/approximate unsigned multiplier
module approx_mult
  import approx_mac_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int APPROX_K = 2
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               mode,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] hi_sum;
  logic [PW-1:0] lo_or;
  logic [PW-1:0] exact_p;

  // Partial-product array: high columns summed exactly, low columns OR-compressed with no carry out.
  always_comb begin
    hi_sum = '0;
    lo_or  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (i + j >= APPROX_K) begin
          hi_sum = hi_sum + (PW'(a[i] & b[j]) << (i + j));
        end else begin
          lo_or = lo_or | (PW'(a[i] & b[j]) << (i + j));
        end
      end
    end
    exact_p = PW'(a) * PW'(b);
  end

  // hi_sum has no bits below APPROX_K, so OR merges the two column groups.
  assign p = mode ? (hi_sum | lo_or) : exact_p;

endmodule

// File: rtl/approx_mac_pipe.sv
// rtl/approx_mac_pipe.sv - pipelined saturating dot-product MAC with per-beat approximate mode
module approx_mac_pipe
  import approx_mac_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int ACC_W    = 16,
  parameter int APPROX_K = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int PW = 2 * WIDTH;

  logic             stall;
  logic             s1_valid, s1_last;
  mac_mode_e        s1_mode;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [PW-1:0]    mult_p;
  logic             s2_valid, s2_last;
  logic [PW-1:0]    s2_prod;
  logic [ACC_W-1:0] acc;
  logic             sticky;
  logic [ACC_W:0]   sum;
  logic             sum_ovf;
  logic [ACC_W-1:0] sum_sat;
  logic             load_last;
  out_state_e       state, state_nxt;

  // A held, unaccepted result freezes the whole pipe; nothing collapses into bubbles.
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = (state == OUT_FULL);
  assign load_last = ~stall & s2_valid & s2_last;

  // Stage 1: capture the operand beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= MODE_EXACT;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_last <= in_last;
        s1_mode <= mac_mode_e'(in_mode);
        s1_a    <= in_a;
        s1_b    <= in_b;
      end
    end
  end

  approx_mult #(
    .WIDTH    (WIDTH),
    .APPROX_K (APPROX_K)
  ) u_mult (
    .a    (s1_a),
    .b    (s1_b),
    .mode (s1_mode == MODE_APPROX),
    .p    (mult_p)
  );

  // Stage 2: register the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_prod  <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last <= s1_last;
        s2_prod <= mult_p;
      end
    end
  end

  // Saturating add of the product into the running dot product.
  always_comb begin
    sum     = {1'b0, acc} + (ACC_W + 1)'(s2_prod);
    sum_ovf = sat_overflow(SAT_SUM_W'(sum), ACC_W);
    sum_sat = sum_ovf ? '1 : sum[ACC_W-1:0];
  end

  // Stage 3: accumulate; a last beat publishes the result and restarts the accumulator cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      sticky   <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (!stall && s2_valid) begin
      if (s2_last) begin
        out_data <= sum_sat;
        out_ovf  <= sticky | sum_ovf;
        acc      <= '0;
        sticky   <= 1'b0;
      end else begin
        acc      <= sum_sat;
        sticky   <= sticky | sum_ovf;
      end
    end
  end

  // Output holding register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // FULL drains on acceptance unless a new result lands in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      OUT_EMPTY: if (load_last) state_nxt = OUT_FULL;
      OUT_FULL:  if (!stall) state_nxt = load_last ? OUT_FULL : OUT_EMPTY;
      default:   state_nxt = OUT_EMPTY;
    endcase
  end

endmodule

// File: tb/tb_approx_mac_pipe.sv
// tb/tb_approx_mac_pipe.sv - self-checking bench for approx_mac_pipe (ACC_W=16 and ACC_W=8 side by side)
module tb_approx_mac_pipe;

  localparam int K = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_mode, in_last, out_ready;
  logic [3:0]  in_a, in_b;
  logic        in_ready16, out_valid16, out_ovf16;
  logic        in_ready8, out_valid8, out_ovf8;
  logic [15:0] out_data16;
  logic [7:0]  out_data8;

  int n_tests = 0;
  int n_fail  = 0;

  int m16, m8;
  bit mo16, mo8;
  bit rnd_done;

  logic [15:0] cap16_d[$], exp16_d[$];
  logic [7:0]  cap8_d[$],  exp8_d[$];
  logic        cap16_o[$], exp16_o[$], cap8_o[$], exp8_o[$];

  approx_mac_pipe #(.WIDTH(4), .ACC_W(16), .APPROX_K(K)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .out_ovf(out_ovf16)
  );

  approx_mac_pipe #(.WIDTH(4), .ACC_W(8), .APPROX_K(K)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .out_ovf(out_ovf8)
  );

  always #5 clk = ~clk;

  // Collect every accepted result from both units.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (out_valid16) begin cap16_d.push_back(out_data16); cap16_o.push_back(out_ovf16); end
      if (out_valid8)  begin cap8_d.push_back(out_data8);   cap8_o.push_back(out_ovf8);   end
    end
  end

  // Reference product: exact product, with each low column's carry-save count replaced by "any bit set".
  function automatic int ref_prod(int a, int b, bit mode);
    int p = a * b;
    if (mode) begin
      for (int c = 0; c < K; c++) begin
        int cnt = 0;
        for (int i = 0; i <= c; i++)
          if (i < 4 && c - i < 4) cnt += ((a >> i) & 1) * ((b >> (c - i)) & 1);
        p = p - cnt * (1 << c) + ((cnt > 0) ? (1 << c) : 0);
      end
    end
    return p;
  endfunction

  function automatic void model_accept(int a, int b, bit mode, bit last);
    int p = ref_prod(a, b, mode);
    m16 += p;
    if (m16 > 65535) begin m16 = 65535; mo16 = 1'b1; end
    m8 += p;
    if (m8 > 255) begin m8 = 255; mo8 = 1'b1; end
    if (last) begin
      exp16_d.push_back(16'(m16)); exp16_o.push_back(mo16);
      exp8_d.push_back(8'(m8));    exp8_o.push_back(mo8);
      m16 = 0; mo16 = 1'b0; m8 = 0; mo8 = 1'b0;
    end
  endfunction

  task automatic model_clear();
    m16 = 0; mo16 = 1'b0; m8 = 0; mo8 = 1'b0;
  endtask

  task automatic flush();
    cap16_d.delete(); cap16_o.delete(); cap8_d.delete(); cap8_o.delete();
    exp16_d.delete(); exp16_o.delete(); exp8_d.delete(); exp8_o.delete();
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Present one beat and hold it until accepted; leaves in_valid high for back-to-back streaming.
  task automatic send_beat(input int a, input int b, input bit mode, input bit last);
    bit done = 1'b0;
    in_valid = 1'b1; in_a = 4'(a); in_b = 4'(b); in_mode = mode; in_last = last;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = in_ready16;
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_beat_timeout: beat (%0d,%0d) not accepted within 200 cycles", a, b);
    end else begin
      model_accept(a, b, mode, last);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 300 && (cap16_d.size() < exp16_d.size() || cap8_d.size() < exp8_d.size()); k++)
      @(negedge clk);
    repeat (4) @(negedge clk);
    n_tests++;
    if (cap16_d.size() != exp16_d.size() || cap8_d.size() != exp8_d.size()) begin
      n_fail++;
      $display("FAIL drain_count: got %0d/%0d results, required %0d/%0d",
               cap16_d.size(), cap8_d.size(), exp16_d.size(), exp8_d.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (out_valid16 !== 1'b0 || out_valid8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b/%b required 0", out_valid16, out_valid8);
    end
    n_tests++;
    if (out_data16 !== 16'd0 || out_data8 !== 8'd0) begin
      n_fail++; $display("FAIL reset_out_data: got %0d/%0d required 0", out_data16, out_data8);
    end
    n_tests++;
    if (out_ovf16 !== 1'b0 || out_ovf8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_ovf: got %b/%b required 0", out_ovf16, out_ovf8);
    end
    n_tests++;
    if (in_ready16 !== 1'b1 || in_ready8 !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b/%b required 1", in_ready16, in_ready8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exact_latency();
    logic exp_v[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    flush();
    out_ready = 1'b1;
    send_beat(3, 3, 1'b0, 1'b1);
    idle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid16 !== exp_v[c]) begin
        n_fail++; $display("FAIL latency_valid_cycle%0d: got %b required %b", c + 1, out_valid16, exp_v[c]);
      end
      if (c == 2) begin
        n_tests++;
        if (out_data16 !== 16'd9 || out_ovf16 !== 1'b0) begin
          n_fail++; $display("FAIL latency_data: got %0d ovf %b required 9 ovf 0", out_data16, out_ovf16);
        end
      end
    end
    @(posedge clk); #1;
    flush();
  endtask

  task automatic test_modes_back_to_back();
    logic [15:0] e[3] = '{16'd7, 16'd223, 16'd225};
    flush();
    send_beat(3, 3, 1'b1, 1'b1);
    send_beat(15, 15, 1'b1, 1'b1);
    send_beat(15, 15, 1'b0, 1'b1);
    idle();
    drain();
    for (int i = 0; i < 3 && i < cap16_d.size() && i < cap8_d.size(); i++) begin
      n_tests++;
      if (cap16_d[i] !== e[i] || cap16_o[i] !== 1'b0) begin
        n_fail++; $display("FAIL modes16_%0d: got %0d ovf %b required %0d ovf 0", i, cap16_d[i], cap16_o[i], e[i]);
      end
      n_tests++;
      if (cap8_d[i] !== e[i][7:0] || cap8_o[i] !== 1'b0) begin
        n_fail++; $display("FAIL modes8_%0d: got %0d ovf %b required %0d ovf 0", i, cap8_d[i], cap8_o[i], e[i][7:0]);
      end
    end
    flush();
  endtask

  task automatic test_dot_product();
    logic [15:0] e[2] = '{16'd232, 16'd1};
    flush();
    send_beat(15, 15, 1'b0, 1'b0);
    send_beat(2, 3, 1'b0, 1'b0);
    send_beat(1, 1, 1'b0, 1'b1);
    send_beat(1, 1, 1'b0, 1'b1);
    idle();
    drain();
    for (int i = 0; i < 2 && i < cap16_d.size() && i < cap8_d.size(); i++) begin
      n_tests++;
      if (cap16_d[i] !== e[i] || cap16_o[i] !== 1'b0 || cap8_d[i] !== e[i][7:0] || cap8_o[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL dot_%0d: got %0d/%b and %0d/%b required %0d/0", i, cap16_d[i], cap16_o[i],
                 cap8_d[i], cap8_o[i], e[i]);
      end
    end
    flush();
  endtask

  task automatic test_saturation();
    logic [15:0] e16[2] = '{16'd450, 16'd2};
    logic [7:0]  e8[2]  = '{8'd255, 8'd2};
    logic        o8[2]  = '{1'b1, 1'b0};
    flush();
    send_beat(15, 15, 1'b0, 1'b0);
    send_beat(15, 15, 1'b0, 1'b1);
    send_beat(1, 2, 1'b0, 1'b1);
    idle();
    drain();
    for (int i = 0; i < 2 && i < cap16_d.size() && i < cap8_d.size(); i++) begin
      n_tests++;
      if (cap8_d[i] !== e8[i] || cap8_o[i] !== o8[i]) begin
        n_fail++; $display("FAIL sat8_%0d: got %0d ovf %b required %0d ovf %b", i, cap8_d[i], cap8_o[i], e8[i], o8[i]);
      end
      n_tests++;
      if (cap16_d[i] !== e16[i] || cap16_o[i] !== 1'b0) begin
        n_fail++; $display("FAIL sat16_%0d: got %0d ovf %b required %0d ovf 0", i, cap16_d[i], cap16_o[i], e16[i]);
      end
    end
    flush();
  endtask

  task automatic test_stall();
    flush();
    out_ready = 1'b0;
    send_beat(1, 3, 1'b0, 1'b1);
    send_beat(2, 3, 1'b1, 1'b1);
    send_beat(5, 7, 1'b0, 1'b1);
    in_valid = 1'b1; in_a = 4'd6; in_b = 4'd6; in_mode = 1'b1; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (in_ready16 !== 1'b0 || out_valid16 !== 1'b1) begin
        n_fail++; $display("FAIL stall_ready_c%0d: in_ready %b out_valid %b required 0/1", c, in_ready16, out_valid16);
      end
      n_tests++;
      if (out_data16 !== exp16_d[0]) begin
        n_fail++; $display("FAIL stall_hold_c%0d: got %0d required %0d", c, out_data16, exp16_d[0]);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_beat(6, 6, 1'b1, 1'b1);
    idle();
    drain();
    for (int i = 0; i < exp16_d.size() && i < cap16_d.size(); i++) begin
      n_tests++;
      if (cap16_d[i] !== exp16_d[i] || cap16_o[i] !== exp16_o[i]) begin
        n_fail++; $display("FAIL stall_order_%0d: got %0d required %0d", i, cap16_d[i], exp16_d[i]);
      end
    end
    flush();
  endtask

  task automatic test_reset_mid();
    flush();
    out_ready = 1'b1;
    send_beat(7, 9, 1'b0, 1'b0);
    send_beat(3, 3, 1'b1, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    n_tests++;
    if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_state: in_ready %b out_valid %b required 1/0", in_ready16, out_valid16);
    end
    @(posedge clk); #1;
    send_beat(2, 2, 1'b0, 1'b1);
    idle();
    drain();
    n_tests++;
    if (cap16_d.size() != 1 || cap8_d.size() != 1) begin
      n_fail++; $display("FAIL rst_mid_count: got %0d/%0d results required 1", cap16_d.size(), cap8_d.size());
    end else begin
      n_tests++;
      if (cap16_d[0] !== 16'd4 || cap16_o[0] !== 1'b0 || cap8_d[0] !== 8'd4 || cap8_o[0] !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_data: got %0d/%0d required 4", cap16_d[0], cap8_d[0]);
      end
    end
    flush();
  endtask

  task automatic test_random();
    flush();
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          bit last = (k == 299) || ($urandom_range(0, 3) == 0);
          send_beat(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), last);
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #2;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();
    for (int i = 0; i < exp16_d.size() && i < cap16_d.size() && i < cap8_d.size(); i++) begin
      n_tests++;
      if (cap16_d[i] !== exp16_d[i] || cap16_o[i] !== exp16_o[i]) begin
        n_fail++; $display("FAIL rand16_%0d: got %0d ovf %b required %0d ovf %b", i, cap16_d[i], cap16_o[i],
                           exp16_d[i], exp16_o[i]);
      end
      n_tests++;
      if (cap8_d[i] !== exp8_d[i] || cap8_o[i] !== exp8_o[i]) begin
        n_fail++; $display("FAIL rand8_%0d: got %0d ovf %b required %0d ovf %b", i, cap8_d[i], cap8_o[i],
                           exp8_d[i], exp8_o[i]);
      end
    end
    flush();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_exact_latency();
    test_modes_back_to_back();
    test_dot_product();
    test_saturation();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
